fp_norm_shift_16bit: RTL and testbench
======================================

Name: fp_norm_shift_16bit

Overview:
- Post-add normalization stage: consumes the 17-bit raw mantissa sum, exponent and sign, plus the leading-one position and zero flag from the 16-bit leading-one position detector.
- Produces a normalized 16-bit mantissa with the leading one at bit 15, an adjusted exponent, and status flags.
- Two-stage pipeline with valid/ready handshake, placed between the adder/LOPD and the rounding unit.

Parameters:
- EXP_W, 8, exponent width in bits; max exponent is 2^EXP_W-1, reserved for Inf.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  synchronous active-high reset.
- i_valid  input  1  upstream data valid.
- o_ready  output  1  block can accept data this cycle.
- i_sign  input  1  sign, passed through unchanged.
- i_exp  input  EXP_W  biased exponent before normalization.
- i_mant  input  17  raw mantissa; bit 16 is the adder carry.
- i_pos_one  input  4  leading-one index of i_mant[15:0], from LOPD.
- i_zero_flag  input  1  i_mant[15:0]==0, from LOPD.
- o_valid  output  1  output data valid.
- i_ready  input  1  downstream accepts.
- o_sign  output  1  registered sign.
- o_exp  output  EXP_W  normalized exponent.
- o_mant  output  16  normalized mantissa; leading one at bit 15 unless subnormal/zero.
- o_guard  output  1  bit shifted out on carry right-shift (i_mant[0]), else 0.
- o_zero  output  1  result is exact zero.
- o_subnormal  output  1  exponent clamped; result is subnormal (o_exp=0).
- o_overflow  output  1  carry pushed exponent to max; o_mant=0 (Inf).

Behaviour:
- Handshake:
  - Transfer in when i_valid&o_ready; transfer out when o_valid&i_ready.
  - o_valid holds, and all outputs are stable, until accepted.
  - Stage k advances when stage k is empty or stage k+1 advances.
  - o_ready = ~s1_valid | s1_advance (combinational from i_ready through the pipe; no bubble at full throughput).
- Latency: 2 cycles accept-to-o_valid with no backpressure. Throughput: 1 per cycle.
- Stage 1 (registered): classify the input and compute shift direction, shift amount (0..15) and new exponent. Classification is first-match, in this order:
  - CARRY (i_mant[16]=1): right shift 1. exp_n = i_exp+1. If exp_n == 2^EXP_W-1, set overflow.
  - ZERO (i_mant[16]=0 & i_zero_flag): shift 0, exp_n=0, zero=1.
  - NORMAL: lz = 15 - i_pos_one.
    - If i_exp > lz: left shift lz, exp_n = i_exp - lz.
    - Else (subnormal): if i_exp==0, shift 0; otherwise left shift i_exp-1. exp_n=0, subnormal=1.
- Stage 2 (registered): barrel shift.
  - CARRY: o_mant = mant[16:1], o_guard = mant[0].
  - Left shift: o_mant = mant[15:0] << sh, zero-fill LSBs, o_guard=0.
  - Overflow: o_mant forced 0, o_exp = 2^EXP_W-1.
- Flags are mutually exclusive; at most one of o_zero/o_subnormal/o_overflow is set.
- No internal check that i_pos_one matches i_mant; an inconsistent input gives defined but meaningless output.
- Exponent arithmetic is unsigned EXP_W bits; the rules above guarantee no wrap.
- Reset: synchronous, all valid bits and all output registers go to 0 (o_valid=0, o_sign=0, o_exp=0, o_mant=0, all flags 0). o_ready=1 in the cycle after reset deasserts.
  - Reset mid-stream drops in-flight data; no partial transfer.
  - i_valid is ignored while i_rst=1.
- Backpressure with both stages full: o_ready=0, contents unchanged. When i_ready rises, the pipe shifts and accepts a new input in the same cycle.

Test Plan:
- Normal shift: i_exp=0x80, i_mant=0x00F00, pos=11 -> after 2 cycles o_mant=0xF000, o_exp=0x7C, all flags 0.
- Carry: i_exp=0x80, i_mant=0x18001 -> o_mant=0xC000, o_exp=0x81, o_guard=1. With i_exp=0xFE -> o_overflow=1, o_exp=0xFF, o_mant=0.
- Subnormal clamp: i_exp=0x03, i_mant=0x00010, pos=4 (lz=11) -> left shift 2, o_mant=0x0040, o_exp=0, o_subnormal=1. With i_exp=0 -> shift 0, o_mant=0x0010.
- Zero: i_mant=0, i_zero_flag=1, i_exp=0x55 -> o_zero=1, o_exp=0, o_mant=0, o_sign=i_sign.
- Backpressure: stream 6 back-to-back items with i_ready=0 for cycles 3-6 -> o_ready drops once both stages are full; no loss or duplication; output order preserved and outputs stable while stalled.
- Reset mid-stream: assert i_rst with 2 items in flight -> next cycle o_valid=0, all outputs 0, o_ready=1 after deassert, and the next accepted item appears 2 cycles later.

Source files
------------

// File: rtl/fp_norm_shift_16bit.sv
// fp_norm_shift_16bit
// Post-add normalization stage for a 16-bit mantissa datapath. Takes the raw
// 17-bit adder sum (bit 16 = carry), the biased exponent and sign, plus the
// leading-one index / zero flag from the LOPD. Produces a mantissa with the
// leading one at bit 15 (unless subnormal or zero), the adjusted exponent
// and exclusive status flags (zero / subnormal / overflow).
//
// Ports:
//   i_clk, i_rst         clock (rising edge), synchronous active-high reset
//   i_valid / o_ready    upstream handshake
//   i_sign, i_exp,       operand: sign, biased exponent (EXP_W bits),
//   i_mant               raw 17-bit mantissa sum
//   i_pos_one,           leading-one index of i_mant[15:0] and its
//   i_zero_flag          all-zero flag, both from the LOPD
//   o_valid / i_ready    downstream handshake
//   o_sign, o_exp,       normalized sign, exponent, 16-bit mantissa
//   o_mant
//   o_guard              bit dropped by the carry right-shift
//   o_zero, o_subnormal, result status, at most one set
//   o_overflow
//
// Handshake (valid/ready): a word moves across an interface on a rising
// edge where valid and ready are both high. Once valid is raised it stays
// high, with data unchanged, until that transfer happens. Ready may depend
// combinationally on the downstream ready (no bubble at full throughput).
//
// Pipeline: stage 1 classifies and computes shift/exponent; stage 2 does the
// barrel shift and drives the output registers. Latency 2, throughput 1.

module fp_norm_shift_16bit #(
  parameter int EXP_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_sign,
  input  logic [EXP_W-1:0] i_exp,
  input  logic [16:0]      i_mant,
  input  logic [3:0]       i_pos_one,
  input  logic             i_zero_flag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_sign,
  output logic [EXP_W-1:0] o_exp,
  output logic [15:0]      o_mant,
  output logic             o_guard,
  output logic             o_zero,
  output logic             o_subnormal,
  output logic             o_overflow
);

  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  // Stage 1 registers
  logic             s1_valid;
  logic             s1_sign;
  logic [EXP_W-1:0] s1_exp;
  logic [16:0]      s1_mant;
  logic [3:0]       s1_sh;
  logic             s1_carry;
  logic             s1_zero;
  logic             s1_sub;
  logic             s1_ovf;

  // Advance: a stage takes new content when it is empty or its content moves on.
  logic s1_advance;
  logic s2_advance;

  assign s2_advance = ~o_valid | i_ready;
  assign s1_advance = ~s1_valid | s2_advance;
  assign o_ready    = s1_advance;

  // Stage 1 classification (first match: carry, zero, normal/subnormal)
  logic [3:0]       c_lz;
  logic [3:0]       c_sub_sh;
  logic [EXP_W-1:0] c_exp_inc;
  logic [EXP_W-1:0] c_exp;
  logic [3:0]       c_sh;
  logic             c_carry;
  logic             c_zero;
  logic             c_sub;
  logic             c_ovf;

  always_comb begin
    c_lz      = 4'd15 - i_pos_one;
    c_exp_inc = i_exp + 1'b1;
    // Only used when i_exp <= lz <= 15, so the low nibble holds the full value.
    c_sub_sh  = i_exp[3:0] - 4'd1;
    c_exp     = '0;
    c_sh      = '0;
    c_carry   = 1'b0;
    c_zero    = 1'b0;
    c_sub     = 1'b0;
    c_ovf     = 1'b0;
    if (i_mant[16]) begin
      c_carry = 1'b1;
      c_exp   = c_exp_inc;
      c_ovf   = (c_exp_inc == EXP_MAX);
    end else if (i_zero_flag) begin
      c_zero = 1'b1;
    end else if (i_exp > EXP_W'(c_lz)) begin
      c_sh  = c_lz;
      c_exp = i_exp - EXP_W'(c_lz);
    end else begin
      // Exponent cannot absorb the full shift: shift until exponent field hits
      // the subnormal encoding (biased 1 behaves as 0 with implicit scale).
      c_sub = 1'b1;
      c_sh  = (i_exp == '0) ? 4'd0 : c_sub_sh;
    end
  end

  // Stage 2 barrel shift
  logic [15:0] c_mant_out;
  logic        c_guard_out;

  always_comb begin
    c_mant_out  = '0;
    c_guard_out = 1'b0;
    if (s1_ovf) begin
      // Infinity: mantissa cleared, no rounding information carried.
      c_mant_out  = '0;
      c_guard_out = 1'b0;
    end else if (s1_carry) begin
      c_mant_out  = s1_mant[16:1];
      c_guard_out = s1_mant[0];
    end else begin
      c_mant_out  = s1_mant[15:0] << s1_sh;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid    <= 1'b0;
      s1_sign     <= 1'b0;
      s1_exp      <= '0;
      s1_mant     <= '0;
      s1_sh       <= '0;
      s1_carry    <= 1'b0;
      s1_zero     <= 1'b0;
      s1_sub      <= 1'b0;
      s1_ovf      <= 1'b0;
      o_valid     <= 1'b0;
      o_sign      <= 1'b0;
      o_exp       <= '0;
      o_mant      <= '0;
      o_guard     <= 1'b0;
      o_zero      <= 1'b0;
      o_subnormal <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      if (s1_advance) begin
        s1_valid <= i_valid;
        if (i_valid) begin
          s1_sign  <= i_sign;
          s1_exp   <= c_exp;
          s1_mant  <= i_mant;
          s1_sh    <= c_sh;
          s1_carry <= c_carry;
          s1_zero  <= c_zero;
          s1_sub   <= c_sub;
          s1_ovf   <= c_ovf;
        end
      end
      if (s2_advance) begin
        o_valid <= s1_valid;
        if (s1_valid) begin
          o_sign      <= s1_sign;
          o_exp       <= s1_exp;
          o_mant      <= c_mant_out;
          o_guard     <= c_guard_out;
          o_zero      <= s1_zero;
          o_subnormal <= s1_sub;
          o_overflow  <= s1_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_norm_shift_16bit.sv
// Bench for fp_norm_shift_16bit: directed cases, backpressure, mid-stream
// reset and a randomized stream scored against a behavioural model.

module tb_fp_norm_shift_16bit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic        i_sign;
  logic [7:0]  i_exp;
  logic [16:0] i_mant;
  logic [3:0]  i_pos_one;
  logic        i_zero_flag;
  logic        o_valid;
  logic        i_ready;
  logic        o_sign;
  logic [7:0]  o_exp;
  logic [15:0] o_mant;
  logic        o_guard;
  logic        o_zero;
  logic        o_subnormal;
  logic        o_overflow;

  always #5 i_clk = ~i_clk;

  fp_norm_shift_16bit #(.EXP_W(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_sign(i_sign), .i_exp(i_exp), .i_mant(i_mant), .i_pos_one(i_pos_one),
    .i_zero_flag(i_zero_flag), .o_valid(o_valid), .i_ready(i_ready),
    .o_sign(o_sign), .o_exp(o_exp), .o_mant(o_mant), .o_guard(o_guard),
    .o_zero(o_zero), .o_subnormal(o_subnormal), .o_overflow(o_overflow)
  );

  // Packed result: {sign, exp[7:0], mant[15:0], guard, zero, sub, ovf}
  logic [28:0] dut_out;
  assign dut_out = {o_sign, o_exp, o_mant, o_guard, o_zero, o_subnormal, o_overflow};

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [28:0] exp_q[$];
  bit          sb_en   = 0;
  bit          have_held = 0;
  logic [28:0] held;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s got=%h expected=%h", tag, got, want);
    end
  endtask

  // Reference: value-level rules for normalizing a 17-bit sum.
  function automatic logic [28:0] model(input logic s, input logic [7:0] e,
                                        input logic [16:0] m, input logic [3:0] p,
                                        input logic z);
    int ei, lz, sh;
    logic [7:0]  eo;
    logic [15:0] mo;
    logic        g;
    logic [2:0]  fl;
    ei = int'(e);
    g  = 1'b0;
    fl = 3'b000;
    eo = 8'h00;
    mo = 16'h0000;
    if (m[16]) begin
      ei = ei + 1;
      if (ei == 255) begin
        eo = 8'hFF;
        fl = 3'b001;
      end else begin
        eo = 8'(ei);
        mo = 16'(int'(m) / 2);
        g  = m[0];
      end
    end else if (z) begin
      fl = 3'b100;
    end else begin
      lz = 15 - int'(p);
      if (ei > lz) begin
        sh = lz;
        eo = 8'(ei - lz);
      end else begin
        sh = (ei == 0) ? 0 : ei - 1;
        fl = 3'b010;
      end
      mo = 16'(int'(m[15:0]) * (1 << sh));
    end
    return {s, eo, mo, g, fl};
  endfunction

  task automatic gen(output logic s, output logic [7:0] e, output logic [16:0] m,
                     output logic [3:0] p, output logic z);
    int kind, lead;
    kind = $urandom_range(0, 5);
    s    = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) == 0) e = 8'($urandom_range(0, 16));
    else                           e = 8'($urandom_range(0, 254));
    if (kind == 0 || kind == 1) begin
      m = {1'b1, 16'($urandom)};
      if (kind == 1) e = 8'($urandom_range(250, 254));
    end else if (kind == 2) begin
      m = 17'h0;
    end else begin
      lead = $urandom_range(0, 15);
      m = 17'((32'd1 << lead) | ($urandom & ((32'd1 << lead) - 1)));
    end
    p = 4'h0;
    z = 1'b1;
    for (int b = 0; b < 16; b++) begin
      if (m[b]) begin
        p = 4'(b);
        z = 1'b0;
      end
    end
  endtask

  task automatic drive(input logic s, input logic [7:0] e, input logic [16:0] m,
                       input logic [3:0] p, input logic z);
    i_sign = s; i_exp = e; i_mant = m; i_pos_one = p; i_zero_flag = z;
  endtask

  // One clock: sample at negedge (scoreboard), then step past the rising edge.
  task automatic cycle(output bit acc, output bit rdy);
    @(negedge i_clk);
    acc = i_valid && o_ready && !i_rst;
    rdy = o_ready;
    if (sb_en && !i_rst) begin
      if (have_held) check("stall_stable", {3'b0, o_valid, dut_out}, {3'b0, 1'b1, held});
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) check("spurious_out", 32'(o_valid), 32'(0));
        else                   check("data", 32'(dut_out), 32'(exp_q.pop_front()));
        have_held = 0;
      end else if (o_valid) begin
        held = dut_out;
        have_held = 1;
      end else begin
        have_held = 0;
      end
      if (acc) exp_q.push_back(model(i_sign, i_exp, i_mant, i_pos_one, i_zero_flag));
    end
    @(posedge i_clk);
    #1;
  endtask

  // Single item through an empty pipe: latency and value against constants.
  task automatic directed(input string tag, input logic s, input logic [7:0] e,
                          input logic [16:0] m, input logic [3:0] p, input logic z,
                          input logic [28:0] want);
    int k;
    drive(s, e, m, p, z);
    i_ready = 1'b1;
    i_valid = 1'b1;
    check({tag, "_ready"}, 32'(o_ready), 32'(1));
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    k = 0;
    while (!o_valid && k < 10) begin
      @(posedge i_clk); #1;
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'(1));
    check(tag, 32'(dut_out), 32'(want));
    @(posedge i_clk); #1;
  endtask

  logic        cs, cz;
  logic [7:0]  ce;
  logic [16:0] cm;
  logic [3:0]  cp;
  bit          acc, rdy;
  int          sent, ready_low;

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    drive(1'b0, 8'h00, 17'h0, 4'h0, 1'b0);
    repeat (3) begin @(posedge i_clk); #1; end
    check("reset_out", {3'b0, o_valid, dut_out}, 32'(0));
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    check("reset_ready", 32'(o_ready), 32'(1));
    check("reset_valid", 32'(o_valid), 32'(0));

    // Directed cases
    directed("normal",   1'b0, 8'h80, 17'h00F00, 4'd11, 1'b0, {1'b0, 8'h7C, 16'hF000, 1'b0, 3'b000});
    directed("carry",    1'b0, 8'h80, 17'h18001, 4'd15, 1'b0, {1'b0, 8'h81, 16'hC000, 1'b1, 3'b000});
    directed("overflow", 1'b1, 8'hFE, 17'h18001, 4'd15, 1'b0, {1'b1, 8'hFF, 16'h0000, 1'b0, 3'b001});
    directed("subnorm",  1'b0, 8'h03, 17'h00010, 4'd4,  1'b0, {1'b0, 8'h00, 16'h0040, 1'b0, 3'b010});
    directed("subnorm0", 1'b0, 8'h00, 17'h00010, 4'd4,  1'b0, {1'b0, 8'h00, 16'h0010, 1'b0, 3'b010});
    directed("zero",     1'b1, 8'h55, 17'h00000, 4'd0,  1'b1, {1'b1, 8'h00, 16'h0000, 1'b0, 3'b100});
    directed("lz0",      1'b0, 8'h01, 17'h08000, 4'd15, 1'b0, {1'b0, 8'h01, 16'h8000, 1'b0, 3'b000});
    directed("lzeq",     1'b0, 8'h0F, 17'h00001, 4'd0,  1'b0, {1'b0, 8'h00, 16'h4000, 1'b0, 3'b010});

    // Backpressure: 6 back-to-back items, downstream stalled on cycles 3..6
    sb_en = 1; have_held = 0; sent = 0; ready_low = 0;
    gen(cs, ce, cm, cp, cz);
    for (int c = 0; c < 30; c++) begin
      i_ready = !(c >= 3 && c <= 6);
      i_valid = (sent < 6);
      drive(cs, ce, cm, cp, cz);
      cycle(acc, rdy);
      if (!rdy) ready_low++;
      if (acc) begin
        sent++;
        gen(cs, ce, cm, cp, cz);
      end
    end
    check("bp_sent", 32'(sent), 32'(6));
    check("bp_drained", 32'(exp_q.size()), 32'(0));
    check("bp_ready_dropped", 32'(ready_low > 0), 32'(1));

    // Randomized stream with random backpressure
    have_held = 0;
    gen(cs, ce, cm, cp, cz);
    for (int c = 0; c < 600; c++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 3) != 0);
      drive(cs, ce, cm, cp, cz);
      cycle(acc, rdy);
      if (acc) gen(cs, ce, cm, cp, cz);
    end
    i_valid = 1'b0; i_ready = 1'b1;
    for (int c = 0; c < 10; c++) cycle(acc, rdy);
    check("rand_drained", 32'(exp_q.size()), 32'(0));
    sb_en = 0;

    // Reset with two items in flight; i_valid high during reset is ignored
    i_ready = 1'b1; i_valid = 1'b1;
    drive(1'b1, 8'h80, 17'h00F00, 4'd11, 1'b0);
    @(posedge i_clk); #1;
    drive(1'b1, 8'h40, 17'h18001, 4'd15, 1'b0);
    @(posedge i_clk); #1;
    check("pre_rst_valid", 32'(o_valid), 32'(1));
    i_rst = 1'b1;
    drive(1'b1, 8'h22, 17'h00100, 4'd8, 1'b0);
    @(posedge i_clk); #1;
    check("midrst_out", {3'b0, o_valid, dut_out}, 32'(0));
    i_rst = 1'b0; i_valid = 1'b0;
    check("midrst_ready", 32'(o_ready), 32'(1));
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    check("midrst_no_ghost", 32'(o_valid), 32'(0));
    directed("post_rst", 1'b0, 8'h80, 17'h00F00, 4'd11, 1'b0, {1'b0, 8'h7C, 16'hF000, 1'b0, 3'b000});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule
